router_pkt_tx: RTL

Packet transmitter for the router 1x3 input port. It accepts a packet request (destination address and length) and a byte stream of payload, buffering the whole payload internally. It then drives header, payload and parity onto the router's `data_in`/`pkt_valid` input without bubbles, stalling on `busy`. It sits upstream of the router, in the design and in the bench's active source agent.

---
 rtl/router_pkt_tx_if.sv | 31 +++
 rtl/router_pkt_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// ============================================================================
// router_pkt_tx_if : request, payload and router-side signals of router_pkt_tx
// Rev 1.0
// ============================================================================
interface router_pkt_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_bad_par;
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] pld_data;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy;
  logic       tx_done;
  logic       req_err;

  // master is the transmitter; slave is the source/sink environment around it
  modport master (
    input  req_valid, req_addr, req_len, req_bad_par, pld_valid, pld_data, busy,
    output req_ready, pld_ready, data_in, pkt_valid, tx_done, req_err
  );
  modport slave (
    output req_valid, req_addr, req_len, req_bad_par, pld_valid, pld_data, busy,
    input  req_ready, pld_ready, data_in, pkt_valid, tx_done, req_err
  );
endinterface
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// router_pkt_tx : buffers a whole payload, then streams header/payload/parity
// Rev 1.0
// ============================================================================
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input wire             clock,
  input wire             resetn,
  router_pkt_tx_if.master bus
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] C_GAP = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SEND   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic [5:0]      len_q, len_d;
  logic            bad_par_q, bad_par_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d;
  logic [7:0]      parity_q, parity_d;
  logic [7:0]      data_q, data_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            tx_done_q, tx_done_d;
  logic            req_err_q, req_err_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      mem_q [0:62];

  logic            req_hs;
  logic            pld_hs;
  logic [7:0]      rd_byte;

  assign req_hs  = bus.req_valid && (state_q == S_IDLE);
  assign pld_hs  = bus.pld_valid && (state_q == S_FILL);
  // Asynchronous read keeps the next byte ready for every consumption edge.
  assign rd_byte = mem_q[idx_q];

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.pld_ready = (state_q == S_FILL);
  assign bus.data_in   = data_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.req_err   = req_err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    bad_par_d   = bad_par_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    gap_d       = gap_q;
    tx_done_d   = 1'b0;
    req_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          if (bus.req_addr == 2'd3 || bus.req_len == 6'd0) begin
            req_err_d = 1'b1;
          end else begin
            addr_d    = bus.req_addr;
            len_d     = bus.req_len;
            bad_par_d = bus.req_bad_par;
            cnt_d     = 6'd0;
            state_d   = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (pld_hs) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) begin
            data_d      = {len_q, addr_q};
            pkt_valid_d = 1'b1;
            parity_d    = {len_q, addr_q};
            idx_d       = 6'd0;
            state_d     = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!bus.busy) begin
          // idx == len means the last payload byte is the one being consumed
          if (idx_q == len_q) begin
            data_d      = bad_par_q ? ~parity_q : parity_q;
            pkt_valid_d = 1'b0;
            state_d     = S_PARITY;
          end else begin
            data_d   = rd_byte;
            parity_d = parity_q ^ rd_byte;
            idx_d    = idx_q + 6'd1;
          end
        end
      end
      S_PARITY: begin
        if (!bus.busy) begin
          data_d    = 8'h00;
          tx_done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = C_GAP;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= 1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      bad_par_q   <= 1'b0;
      cnt_q       <= 6'd0;
      idx_q       <= 6'd0;
      parity_q    <= 8'h00;
      data_q      <= 8'h00;
      pkt_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      req_err_q   <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      bad_par_q   <= bad_par_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      tx_done_q   <= tx_done_d;
      req_err_q   <= req_err_d;
      gap_q       <= gap_d;
    end
  end

  always_ff @(posedge clock) begin
    if (pld_hs) begin
      mem_q[cnt_q] <= bus.pld_data;
    end
  end

endmodule
`default_nettype wire
